fminmax_stream: RTL and testbench

Streaming single-precision reduction unit: accepts a packet of IEEE-754 binary32 values over a valid/ready input and returns the minimum, the maximum and the element count over a valid/ready output. The ordering is the FPU's `fle` ordering: denormals are flushed to zero and -0 equals +0. The block sits downstream of the FPU datapath and consumes the same compare semantics sequentially, so that a packet-level min/max can be produced without a software loop over `fle`.

---
 rtl/fminmax_stream.sv | 136 +++++++++++++
 tb/tb_fminmax_stream.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fminmax_stream.sv
// fminmax_stream
// Streaming binary32 min/max/count reduction over one packet at a time.
// Elements are ordered by the FPU's fle semantics: denormals flush to zero,
// -0 == +0, and NaNs sort outside the infinities by their sign. The stored
// results are the original input bit patterns, never the flushed values.
module fminmax_stream #(
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_min,
    output logic [31:0]        out_max,
    output logic [COUNT_W-1:0] out_count
);

    // Packet phases: waiting for first element, accumulating, holding result.
    localparam logic [1:0] ST_FIRST = 2'd0;
    localparam logic [1:0] ST_ACC   = 2'd1;
    localparam logic [1:0] ST_OUT   = 2'd2;

    localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    logic [1:0]         state_q, state_d;
    logic [31:0]        min_q, min_d;
    logic [31:0]        max_q, max_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic               in_fire;
    logic               out_fire;
    logic [31:0]        in_key;
    logic [31:0]        min_key;
    logic [31:0]        max_key;
    logic               in_below_min;
    logic               in_above_max;

    // Map a binary32 pattern to an unsigned key whose integer order is the
    // fle order. Every zero/denormal collapses onto the key of +0; positive
    // values get the top bit set so they sit above all negatives, and
    // negatives are bit-inverted so a larger magnitude gives a smaller key.
    function automatic logic [31:0] order_key(input logic [31:0] x);
        logic [31:0] k;
        if (x[30:23] == 8'h00) begin
            k = 32'h8000_0000;
        end else if (!x[31]) begin
            k = {1'b1, x[30:0]};
        end else begin
            k = {1'b0, ~x[30:0]};
        end
        return k;
    endfunction

    assign in_ready  = (state_q != ST_OUT);
    assign out_valid = (state_q == ST_OUT);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    assign in_key  = order_key(in_data);
    assign min_key = order_key(min_q);
    assign max_key = order_key(max_q);

    // Strict comparisons so that ties keep the earliest element.
    assign in_below_min = (in_key < min_key);
    assign in_above_max = (in_key > max_key);

    assign out_min   = min_q;
    assign out_max   = max_q;
    assign out_count = count_q;

    // Next-state logic for the packet FSM and the running min/max/count.
    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        max_d   = max_q;
        count_d = count_q;
        case (state_q)
            ST_FIRST: begin
                if (in_fire) begin
                    min_d   = in_data;
                    max_d   = in_data;
                    count_d = COUNT_ONE;
                    state_d = in_last ? ST_OUT : ST_ACC;
                end
            end
            ST_ACC: begin
                if (in_fire) begin
                    if (in_below_min) begin
                        min_d = in_data;
                    end
                    if (in_above_max) begin
                        max_d = in_data;
                    end
                    // Saturate: once all-ones, extra elements are not counted.
                    if (count_q != COUNT_MAX) begin
                        count_d = count_q + COUNT_ONE;
                    end
                    if (in_last) begin
                        state_d = ST_OUT;
                    end
                end
            end
            ST_OUT: begin
                // Inputs are stalled here, so an output transfer can never
                // coincide with the start of the next packet.
                if (out_fire) begin
                    state_d = ST_FIRST;
                end
            end
            default: begin
                state_d = ST_FIRST;
            end
        endcase
    end

    // State and result registers; asynchronous reset discards any packet.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_FIRST;
            min_q   <= 32'h0;
            max_q   <= 32'h0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            max_q   <= max_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_fminmax_stream.sv
// Testbench for fminmax_stream: two instances (16-bit and 2-bit counters)
// share all inputs; results are compared against a packet-level model.
module tb_fminmax_stream;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_ready;

    logic        a_in_ready, a_out_valid;
    logic [31:0] a_min, a_max;
    logic [15:0] a_count;
    logic        b_in_ready, b_out_valid;
    logic [31:0] b_min, b_max;
    logic [1:0]  b_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] pkt[$];

    always #5 clk = ~clk;

    fminmax_stream #(.COUNT_W(16)) dut_a (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (a_in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (a_out_valid),
        .out_ready (out_ready),
        .out_min   (a_min),
        .out_max   (a_max),
        .out_count (a_count)
    );

    fminmax_stream #(.COUNT_W(2)) dut_b (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (b_in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (b_out_valid),
        .out_ready (out_ready),
        .out_min   (b_min),
        .out_max   (b_max),
        .out_count (b_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Ordering key taken directly from the fle definition.
    function automatic logic [31:0] ref_key(input logic [31:0] x);
        if (x[30:23] == 8'h00) return 32'h8000_0000;
        if (x[31] == 1'b0)     return {1'b1, x[30:0]};
        return {1'b0, ~x[30:0]};
    endfunction

    // Random element biased towards the interesting classes.
    function automatic logic [31:0] rand_elem();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: return {r[31], 31'h0};                  // signed zero
            1: return {r[31], 8'h00, r[22:0]};         // denormal
            2: return {r[31], 8'hFF, 23'h0};           // infinity
            3: return {r[31], 8'hFF, r[22:0] | 23'h1}; // NaN
            4: return {r[31], 8'h7F, 23'h0};           // +/-1.0 (ties)
            default: return r;
        endcase
    endfunction

    // Drive the packet in pkt, check the result, hold it for 'hold' cycles
    // while a pending element is presented, then complete the output transfer.
    task automatic run_packet(input int hold, input logic [31:0] pend);
        logic [31:0] exp_min, exp_max, exp_ca, exp_cb;
        int n;
        n = pkt.size();
        exp_min = pkt[0];
        exp_max = pkt[0];
        foreach (pkt[i]) begin
            if (ref_key(pkt[i]) < ref_key(exp_min)) exp_min = pkt[i];
            if (ref_key(pkt[i]) > ref_key(exp_max)) exp_max = pkt[i];
        end
        exp_ca = (n > 65535) ? 32'd65535 : 32'(n);
        exp_cb = (n > 3) ? 32'd3 : 32'(n);

        out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = pkt[i];
            in_last  = (i == n - 1);
            check_eq("in_ready_acc", {31'b0, a_in_ready}, 32'd1);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;

        check_eq("out_valid", {31'b0, a_out_valid}, 32'd1);
        check_eq("min_a", a_min, exp_min);
        check_eq("max_a", a_max, exp_max);
        check_eq("count_a", {16'b0, a_count}, exp_ca);
        check_eq("min_b", b_min, exp_min);
        check_eq("max_b", b_max, exp_max);
        check_eq("count_b", {30'b0, b_count}, exp_cb);
        $display("packet n=%0d min=%08h max=%08h count16=%0d count2=%0d hold=%0d",
                 n, a_min, a_max, a_count, b_count, hold);

        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_data  = pend;
            in_last  = 1'b1;
            check_eq("in_ready_out", {31'b0, a_in_ready}, 32'd0);
            step();
            check_eq("hold_valid", {31'b0, a_out_valid}, 32'd1);
            check_eq("hold_min", a_min, exp_min);
            check_eq("hold_max", a_max, exp_max);
            check_eq("hold_count", {16'b0, a_count}, exp_ca);
        end

        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq("valid_drop", {31'b0, a_out_valid}, 32'd0);
        check_eq("ready_back", {31'b0, a_in_ready}, 32'd1);
        check_eq("ready_back_b", {31'b0, b_in_ready}, 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #2;
        check_eq("rst_valid", {31'b0, a_out_valid}, 32'd0);
        check_eq("rst_min", a_min, 32'h0);
        check_eq("rst_max", a_max, 32'h0);
        check_eq("rst_count", {16'b0, a_count}, 32'd0);
        step();
        step();
        rstn = 1'b1;
        step();
        check_eq("rst_ready", {31'b0, a_in_ready}, 32'd1);

        // Basic packet
        pkt = '{32'h3F800000, 32'hC0000000, 32'h40600000};
        run_packet(0, 32'h0);
        // Zero/denormal ties: first element wins both
        pkt = '{32'h80000000, 32'h00000000, 32'h00000001};
        run_packet(0, 32'h0);
        // Infinities and NaN
        pkt = '{32'hFF800000, 32'h7FC00000, 32'h7F800000};
        run_packet(1, 32'h0);
        // Backpressure with a pending element that becomes the next packet
        pkt = '{32'h40490FDB};
        run_packet(5, 32'h3F800000);
        pkt = '{32'h3F800000};
        run_packet(0, 32'h0);
        // Saturation of the 2-bit counter
        pkt = '{32'h3F800000, 32'h40000000, 32'hBF800000, 32'h3F000000, 32'h40400000};
        run_packet(0, 32'h0);

        // Reset mid-packet
        in_valid = 1'b1;
        in_last  = 1'b0;
        in_data  = 32'h41200000;
        step();
        in_data  = 32'h3F800000;
        step();
        in_valid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        check_eq("arst_valid", {31'b0, a_out_valid}, 32'd0);
        check_eq("arst_min", a_min, 32'h0);
        check_eq("arst_max", a_max, 32'h0);
        check_eq("arst_count", {16'b0, a_count}, 32'd0);
        check_eq("arst_count_b", {30'b0, b_count}, 32'd0);
        #3;
        rstn = 1'b1;
        step();
        pkt = '{32'hC1200000};
        run_packet(0, 32'h0);

        // Randomized packets
        for (int p = 0; p < 40; p++) begin
            int len;
            len = $urandom_range(1, 12);
            pkt.delete();
            for (int i = 0; i < len; i++) pkt.push_back(rand_elem());
            run_packet($urandom_range(0, 3), rand_elem());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
